// File: rtl/rt_pkg.sv
// ----------------------------------------------------------------------------
// rt_pkg
// Shared definitions for the ray-tracer pixel output path.
//   FP_WL            : width of one pixel word
//   COORDINATE_BITS  : width of frame coordinates (image_width/height, ox/oy)
//   rt_entry_t       : one buffered pixel, {last, pixel}
// ----------------------------------------------------------------------------
package rt_pkg;

  localparam int FP_WL           = 16;
  localparam int COORDINATE_BITS = 12;

  typedef struct packed {
    logic             last;
    logic [FP_WL-1:0] pixel;
  } rt_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// ----------------------------------------------------------------------------
// rt_sync_fifo
// Single-clock pixel FIFO with a registered occupancy count. Besides the
// current head it exposes the head and count as they will be after this
// cycle's push/pop, so the caller can register its output stage from them.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset (pointers/count)
//   push, pop          : qualified push / pop strobes (caller guarantees legality)
//   wdata              : entry to write
//   head_last          : stored last flag of the current head entry
//   head_nxt           : head entry after this cycle's push/pop
//   count, count_nxt   : occupancy now / after this cycle
//   full               : count == DEPTH
// ----------------------------------------------------------------------------
module rt_sync_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  rt_entry_t                wdata,
  output logic                     head_last,
  output rt_entry_t                head_nxt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     full
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  rt_entry_t         mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     rptr_nxt;

  assign full      = (count == FULL_CNT);
  assign head_last = mem[rptr].last;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  assign rptr_nxt = pop ? rptr + 1'b1 : rptr;

  // When the FIFO is (or becomes) empty apart from the incoming word, the
  // new head is the write data itself rather than anything in storage.
  always_comb begin
    head_nxt = mem[rptr_nxt];
    if (push && ((count == '0) || ((count == (AW+1)'(1)) && pop)))
      head_nxt = wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      rptr  <= rptr_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/rt_axis_out.sv
// ----------------------------------------------------------------------------
// rt_axis_out
// Buffers pixels from the ray-tracer core and emits them as an AXI4-Stream
// video stream (tuser = start of frame, tlast = end of line).
// Optional build macro: RT_AXIS_OUT_FRAME_CHECK_EN enables the sticky
// frame-consistency check on frame_err; otherwise frame_err is tied to 0.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   in_valid, in_last, in_pixel : upstream pixel, end-of-frame marker
//   stall                       : registered back-pressure to upstream
//   image_width, image_height   : frame geometry (0 treated as 1)
//   m_axis_tdata/tvalid/tready  : AXI4-Stream data handshake
//   m_axis_tuser, m_axis_tlast  : start of frame, end of line
//   frame_err                   : sticky frame-consistency error
// ----------------------------------------------------------------------------
module rt_axis_out
  import rt_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [FP_WL-1:0]           in_pixel,
  output logic                       stall,
  input  logic [COORDINATE_BITS-1:0] image_width,
  input  logic [COORDINATE_BITS-1:0] image_height,
  output logic [FP_WL-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       frame_err
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   STALL_LVL = CW'(DEPTH - STALL_MARGIN);

  logic                        push;
  logic                        pop;
  rt_entry_t                   wdata;
  logic                        head_last;
  rt_entry_t                   head_nxt;
  logic [CW-1:0]               count;
  logic [CW-1:0]               count_nxt;
  logic                        full;
  logic [COORDINATE_BITS-1:0]  w_m1;
  logic [COORDINATE_BITS-1:0]  ox;
  logic [COORDINATE_BITS-1:0]  oy;
  logic [COORDINATE_BITS-1:0]  ox_nxt;
  logic [COORDINATE_BITS-1:0]  oy_nxt;

  // The output register always mirrors the FIFO head, so tvalid=1 implies
  // the FIFO holds at least one entry and the handshake pops it directly.
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign push  = in_valid & (~full | pop);
  assign wdata = '{last: in_last, pixel: in_pixel};

  rt_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .head_last (head_last),
    .head_nxt  (head_nxt),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full)
  );

  assign w_m1 = (image_width == '0) ? '0 : image_width - 1'b1;

  // ox/oy always name the position of the current head pixel.
  always_comb begin
    ox_nxt = ox;
    oy_nxt = oy;
    if (pop) begin
      if (head_last) begin
        ox_nxt = '0;
        oy_nxt = '0;
      end else if (ox >= w_m1) begin
        ox_nxt = '0;
        oy_nxt = oy + 1'b1;
      end else begin
        ox_nxt = ox + 1'b1;
      end
    end
  end

  // Output stage: registered image of the post-cycle FIFO head.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox            <= '0;
      oy            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      stall         <= 1'b0;
    end else begin
      ox            <= ox_nxt;
      oy            <= oy_nxt;
      m_axis_tvalid <= (count_nxt != '0);
      m_axis_tdata  <= head_nxt.pixel;
      m_axis_tuser  <= (ox_nxt == '0) && (oy_nxt == '0);
      m_axis_tlast  <= (ox_nxt == w_m1);
      stall         <= (count_nxt >= STALL_LVL);
    end
  end

`ifdef RT_AXIS_OUT_FRAME_CHECK_EN
  logic [COORDINATE_BITS-1:0] h_m1;
  logic                       at_end;

  assign h_m1   = (image_height == '0) ? '0 : image_height - 1'b1;
  assign at_end = (ox == w_m1) && (oy == h_m1);

  // A marked last pixel off the final position, or the final position
  // without the mark, both indicate upstream and geometry disagree.
  always_ff @(posedge clk) begin
    if (!resetn)
      frame_err <= 1'b0;
    else if (pop && (head_last != at_end))
      frame_err <= 1'b1;
  end
`else
  logic unused_height;
  assign unused_height = ^image_height;
  assign frame_err     = 1'b0;
`endif

endmodule

// File: doc/rt_axis_out.md
RT_AXIS_OUT -- requirements
Module: rt_axis_out

Interface
REQ-001 SHALL have parameter DEPTH, default 8, pixel FIFO entries (power of two, >= 4).
REQ-002 SHALL have parameter STALL_MARGIN, default 6, free entries reserved for in-flight upstream pixels (< DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream pixel valid.
REQ-006 SHALL have port in_last  input  1  upstream final-pixel-of-frame marker.
REQ-007 SHALL have port in_pixel  input  FP_WL  upstream pixel word.
REQ-008 SHALL have port stall  output  1  back-pressure to upstream core.
REQ-009 SHALL have port image_width, image_height  input  COORDINATE_BITS each  frame geometry, stable for a whole frame.
REQ-010 SHALL have port m_axis_tdata  output  FP_WL  AXI4-Stream pixel.
REQ-011 SHALL have port m_axis_tvalid  output  1  AXI4-Stream valid.
REQ-012 SHALL have port m_axis_tready  input  1  AXI4-Stream ready.
REQ-013 SHALL have port m_axis_tuser  output  1  start of frame.
REQ-014 SHALL have port m_axis_tlast  output  1  end of line.
REQ-015 SHALL have port frame_err  output  1  sticky frame-consistency error.

Function
REQ-016 SHALL push {in_last, in_pixel} into the FIFO every cycle that in_valid=1 and the FIFO is not full, regardless of stall.
REQ-017 SHALL drop the pixel when in_valid=1 and the FIFO is full; no other state changes.
REQ-018 SHALL drive stall from a register: 1 when occupancy >= DEPTH-STALL_MARGIN after the current cycle's push and pop, otherwise 0.
REQ-019 SHALL present the FIFO head on m_axis_* from an output register; a pixel pushed in cycle N SHALL be visible no earlier than cycle N+1.
REQ-020 SHALL keep m_axis_tdata/tuser/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL pop one pixel per cycle when m_axis_tvalid=1 and m_axis_tready=1, sustaining 1 pixel/cycle throughput.
REQ-022 SHALL keep output counters ox, oy advancing on each pop; ox wraps to 0 at image_width-1 with oy incrementing.
REQ-023 SHALL assert m_axis_tuser with the pixel at ox=0, oy=0.
REQ-024 SHALL assert m_axis_tlast with the pixel at ox=image_width-1.
REQ-025 SHALL reset ox and oy to 0 after popping a pixel whose stored in_last=1, independent of counter values.
REQ-026 SHALL treat image_width=0 or image_height=0 as 1.
REQ-027 SHALL, on simultaneous push and pop while full, accept the push (occupancy unchanged).

Reset
REQ-028 SHALL, while resetn=0, force: FIFO empty, ox=oy=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, stall=0, frame_err=0.
REQ-029 SHALL, on reset mid-frame, discard all buffered pixels; the first pixel after reset carries tuser=1.

Configuration
REQ-030 SHALL implement frame checking only when RT_AXIS_OUT_FRAME_CHECK_EN is defined: frame_err sets when a popped in_last=1 pixel is not at (image_width-1, image_height-1), or when the pixel at that position has in_last=0, and frame_err clears only on reset.
REQ-031 SHALL, without RT_AXIS_OUT_FRAME_CHECK_EN, tie frame_err to 0 and use image_height for no logic.

Structure
REQ-032 SHALL take FP_WL and COORDINATE_BITS from parameters.vh; a FIFO entry typedef {last, pixel} SHALL live in shared package rt_pkg.
REQ-033 SHALL implement buffering in one sub-module rt_sync_fifo (DEPTH, synchronous, registered count).

Verification
REQ-034 SHALL cover: width=4, height=2, 8 pixels, tready=1 -> tuser on pixel 0 only, tlast on pixels 3 and 7, 1 pixel/cycle.
REQ-035 SHALL cover: tready=0 with continuous in_valid -> stall=1 once occupancy reaches 2, no drop with 6-cycle upstream latency, data intact after tready=1.
REQ-036 SHALL cover: 9 pushes into DEPTH=8 with tready=0 and stall ignored -> 9th pixel dropped, first 8 emerge in order.
REQ-037 SHALL cover: resetn=0 for 1 cycle mid-frame (pixel 5 of 8) -> outputs cleared, next frame starts with tuser=1.
REQ-038 SHALL cover (macro defined): in_last on pixel 6 of 4x2 frame -> frame_err=1 from that pop; macro undefined -> frame_err stays 0.
REQ-039 SHALL cover: random tready toggling over 3 frames of 5x3 -> scoreboard matches, tdata stable while tvalid=1 and tready=0.
